// File: rtl/mac_sequencer.sv
// -----------------------------------------------------------------------------
// mac_sequencer
//
// Control sequencer for the multiply-accumulate datapath. A start request
// launches a frame of NUM_OUTS dot products of NUM_CYC beats each. One beat is
// issued per cycle: the beat index goes to the input-vector buffer and
// out_idx*NUM_CYC + beat goes to the weight memory. Two delay lines follow the
// issue stream:
//   - alignment line (RAM_LAT deep): marks beats arriving at the MAC inputs and
//     raises new_sum on beat 0 of each dot product;
//   - result line (RAM_LAT+MAC_LAT deep): marks the cycle a final sum sits on
//     the MAC output, tags it with its output index, and flags the frame's last.
//
// Parameters:
//   NUM_CYC  beats per dot product (>= 2)
//   NUM_OUTS dot products per frame (>= 1)
//   RAM_LAT  buffer / weight memory read latency in cycles (>= 1)
//   MAC_LAT  last beat at MAC inputs -> final sum valid, in cycles (>= 1)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        frame request, accepted when idle (or on the done cycle)
//   busy         frame in progress
//   buf_rd_addr  input-buffer read address (beat index)
//   w_rd_addr    weight read address (out_idx*NUM_CYC + beat)
//   rd_en        memory read enable, high on every issue cycle
//   new_sum      beat 0 of a dot product is at the MAC inputs
//   mac_valid    any beat is at the MAC inputs
//   res_valid    MAC data_out holds a final sum
//   res_idx      output index of that sum
//   done         pulse with the last result of the frame
//   overrun      (MAC_SEQ_OVERRUN_DETECT_EN only) sticky: start seen while busy
//
// Optional feature macro: MAC_SEQ_OVERRUN_DETECT_EN adds the overrun output.
// Sequencing is identical with or without it.
// -----------------------------------------------------------------------------
module mac_sequencer #(
    parameter  int NUM_CYC  = 32,
    parameter  int NUM_OUTS = 8,
    parameter  int RAM_LAT  = 1,
    parameter  int MAC_LAT  = 4,
    localparam int BW_BADDR = $clog2(NUM_CYC),
    localparam int BW_WADDR = $clog2(NUM_OUTS * NUM_CYC),
    localparam int BW_OIDX  = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic [BW_BADDR-1:0] buf_rd_addr,
    output logic [BW_WADDR-1:0] w_rd_addr,
    output logic                rd_en,
    output logic                new_sum,
    output logic                mac_valid,
    output logic                res_valid,
    output logic [BW_OIDX-1:0]  res_idx,
    output logic                done
`ifdef MAC_SEQ_OVERRUN_DETECT_EN
    ,
    output logic                overrun
`endif
);

    localparam int RES_DEPTH = RAM_LAT + MAC_LAT;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_e;

    // Entry of the alignment line: one beat heading for the MAC inputs.
    typedef struct packed {
        logic valid;
        logic first;
    } align_t;

    // Entry of the result line: a final sum heading for the MAC output.
    typedef struct packed {
        logic               valid;
        logic [BW_OIDX-1:0] idx;
        logic               last;
    } res_t;

    state_e              state_q, state_d;
    logic [BW_BADDR-1:0] beat_q, beat_d;
    logic [BW_OIDX-1:0]  oidx_q, oidx_d;
    logic [BW_WADDR-1:0] waddr_q, waddr_d;

    align_t align_q [RAM_LAT];
    res_t   res_q   [RES_DEPTH];

    logic issuing;
    logic first_beat;
    logic last_beat;
    logic last_out;
    logic res_done;
    logic accept;

    assign issuing    = (state_q == S_ISSUE);
    assign first_beat = (beat_q == '0);
    assign last_beat  = (beat_q == BW_BADDR'(NUM_CYC - 1));
    assign last_out   = (oidx_q == BW_OIDX'(NUM_OUTS - 1));
    assign res_done   = res_q[RES_DEPTH-1].last;

    // A request is taken when idle, and also on the done cycle itself so that a
    // held start chains frames without an idle cycle between them.
    assign accept = start && ((state_q == S_IDLE) || ((state_q == S_DRAIN) && res_done));

    // -------------------------------------------------------------------------
    // FSM and counters: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        beat_d  = beat_q;
        oidx_d  = oidx_q;
        waddr_d = waddr_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    beat_d  = '0;
                    oidx_d  = '0;
                    waddr_d = '0;
                end
            end

            S_ISSUE: begin
                waddr_d = waddr_q + BW_WADDR'(1);
                if (last_beat) begin
                    beat_d = '0;
                    oidx_d = oidx_q + BW_OIDX'(1);
                    if (last_out) begin
                        // Park the counters at zero so addresses read 0 outside
                        // of issue cycles.
                        state_d = S_DRAIN;
                        oidx_d  = '0;
                        waddr_d = '0;
                    end
                end else begin
                    beat_d = beat_q + BW_BADDR'(1);
                end
            end

            S_DRAIN: begin
                // Counters are already parked at zero, ready for a chained frame.
                if (res_done) begin
                    state_d = accept ? S_ISSUE : S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM and counters: state registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is updated with non-blocking assignments so all
        // registers see pre-edge values; the combinational block above uses
        // blocking assignments because it only computes values.
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            oidx_q  <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            oidx_q  <= oidx_d;
            waddr_q <= waddr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Alignment and result delay lines
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: both delay lines are reset entry by entry; a stale valid bit
            // left in flight would otherwise surface as a spurious new_sum,
            // res_valid or done after reset release.
            for (int i = 0; i < RAM_LAT; i++) begin
                align_q[i] <= '0;
            end
            for (int i = 0; i < RES_DEPTH; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            align_q[0] <= '{valid: issuing, first: issuing && first_beat};
            for (int i = 1; i < RAM_LAT; i++) begin
                align_q[i] <= align_q[i-1];
            end

            // The index is only loaded alongside a valid flag so res_idx reads
            // 0 whenever no result is presented.
            res_q[0] <= '{valid: issuing && last_beat,
                          idx:   (issuing && last_beat) ? oidx_q : '0,
                          last:  issuing && last_beat && last_out};
            for (int i = 1; i < RES_DEPTH; i++) begin
                res_q[i] <= res_q[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all driven from registers)
    // -------------------------------------------------------------------------
    assign busy        = (state_q != S_IDLE);
    assign rd_en       = issuing;
    assign buf_rd_addr = beat_q;
    assign w_rd_addr   = waddr_q;
    assign mac_valid   = align_q[RAM_LAT-1].valid;
    assign new_sum     = align_q[RAM_LAT-1].first;
    assign res_valid   = res_q[RES_DEPTH-1].valid;
    assign res_idx     = res_q[RES_DEPTH-1].idx;
    assign done        = res_done;

`ifdef MAC_SEQ_OVERRUN_DETECT_EN
    // Sticky flag for requests that arrive while a frame is running and are not
    // the one taken on the done cycle.
    logic overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (start && busy && !accept) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for mac_sequencer: a table of single-frame checkpoints,
// hand sequences for the multi-cycle corners, and a randomized run compared
// cycle by cycle against a timing-formula reference model.
module tb_mac_sequencer;

    localparam int NC  = 4;
    localparam int NO  = 3;
    localparam int RL  = 1;
    localparam int ML  = 3;
    localparam int NO2 = 1;
    localparam int RL2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic       rst, start;
    logic       busy, rd_en, new_sum, mac_valid, res_valid, done;
    logic [1:0] buf_rd_addr;
    logic [3:0] w_rd_addr;
    logic [1:0] res_idx;

    // Parameter-corner instance
    logic       rst2, start2;
    logic       busy2, rd_en2, new_sum2, mac_valid2, res_valid2, done2;
    logic [1:0] buf_rd_addr2;
    logic [1:0] w_rd_addr2;
    logic [0:0] res_idx2;

`ifdef MAC_SEQ_OVERRUN_DETECT_EN
    logic overrun, overrun2;
`endif

    mac_sequencer #(.NUM_CYC(NC), .NUM_OUTS(NO), .RAM_LAT(RL), .MAC_LAT(ML)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .buf_rd_addr(buf_rd_addr), .w_rd_addr(w_rd_addr), .rd_en(rd_en),
        .new_sum(new_sum), .mac_valid(mac_valid), .res_valid(res_valid),
        .res_idx(res_idx), .done(done)
`ifdef MAC_SEQ_OVERRUN_DETECT_EN
        , .overrun(overrun)
`endif
    );

    mac_sequencer #(.NUM_CYC(NC), .NUM_OUTS(NO2), .RAM_LAT(RL2), .MAC_LAT(ML)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .busy(busy2),
        .buf_rd_addr(buf_rd_addr2), .w_rd_addr(w_rd_addr2), .rd_en(rd_en2),
        .new_sum(new_sum2), .mac_valid(mac_valid2), .res_valid(res_valid2),
        .res_idx(res_idx2), .done(done2)
`ifdef MAC_SEQ_OVERRUN_DETECT_EN
        , .overrun(overrun2)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc  = 0;   // main instance cycle index within the current scenario
    int t_m  = -1;  // cycle at which the model accepted the running frame
    int cyc2 = 0;
    int t2   = -1;

    typedef struct {
        logic rd_en, busy, new_sum, mac_valid, res_valid, done;
        int   res_idx, waddr, baddr;
    } exp_t;

    // Reference model: expected outputs at cycle c for a frame accepted at t,
    // straight from the frame timing rules.
    function automatic exp_t model(int nc, int no, int rl, int ml, int c, int t);
        exp_t e;
        int k, m, r;
        e.rd_en = 0; e.busy = 0; e.new_sum = 0; e.mac_valid = 0;
        e.res_valid = 0; e.done = 0; e.res_idx = 0; e.waddr = 0; e.baddr = 0;
        if (t < 0) return e;
        k = c - t - 1;        // issue slot index
        m = k - rl;           // slot at the MAC inputs
        r = c - t - rl - ml;  // multiple of nc when a sum is out
        e.busy = (c - t >= 1) && (c - t <= no * nc + rl + ml);
        if (k >= 0 && k < no * nc) begin
            e.rd_en = 1; e.waddr = k; e.baddr = k % nc;
        end
        if (m >= 0 && m < no * nc) begin
            e.mac_valid = 1; e.new_sum = (m % nc == 0);
        end
        if (r > 0 && r % nc == 0 && r / nc <= no) begin
            e.res_valid = 1; e.res_idx = r / nc - 1; e.done = (r / nc == no);
        end
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp_v, input int at);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, at, act, exp_v);
        end
    endtask

    task automatic cmp_main();
        exp_t e;
        e = model(NC, NO, RL, ML, cyc, t_m);
        check("rd_en", rd_en, e.rd_en, cyc);
        check("busy", busy, e.busy, cyc);
        check("new_sum", new_sum, e.new_sum, cyc);
        check("mac_valid", mac_valid, e.mac_valid, cyc);
        check("res_valid", res_valid, e.res_valid, cyc);
        check("done", done, e.done, cyc);
        if (e.rd_en) begin
            check("w_rd_addr", w_rd_addr, e.waddr, cyc);
            check("buf_rd_addr", buf_rd_addr, e.baddr, cyc);
        end
        if (e.res_valid) check("res_idx", res_idx, e.res_idx, cyc);
    endtask

    task automatic cmp_corner();
        exp_t e;
        e = model(NC, NO2, RL2, ML, cyc2, t2);
        check("c_rd_en", rd_en2, e.rd_en, cyc2);
        check("c_busy", busy2, e.busy, cyc2);
        check("c_new_sum", new_sum2, e.new_sum, cyc2);
        check("c_mac_valid", mac_valid2, e.mac_valid, cyc2);
        check("c_res_valid", res_valid2, e.res_valid, cyc2);
        check("c_done", done2, e.done, cyc2);
        if (e.rd_en) begin
            check("c_w_rd_addr", w_rd_addr2, e.waddr, cyc2);
            check("c_buf_rd_addr", buf_rd_addr2, e.baddr, cyc2);
        end
        if (e.res_valid) check("c_res_idx", res_idx2, e.res_idx, cyc2);
    endtask

    // Drive inputs for the current cycle, advance one clock, compare.
    task automatic step(input logic s, input logic r);
        exp_t e;
        e = model(NC, NO, RL, ML, cyc, t_m);
        start = s;
        rst   = r;
        if (r) t_m = -1;
        else if (s && (t_m < 0 || !e.busy || e.done)) t_m = cyc;
        @(posedge clk);
        cyc++;
        #1;
        cmp_main();
    endtask

    task automatic step2(input logic s, input logic r);
        exp_t e;
        e = model(NC, NO2, RL2, ML, cyc2, t2);
        start2 = s;
        rst2   = r;
        if (r) t2 = -1;
        else if (s && (t2 < 0 || !e.busy || e.done)) t2 = cyc2;
        @(posedge clk);
        cyc2++;
        #1;
        cmp_corner();
    endtask

    task automatic begin_scenario();
        step(1'b0, 1'b1);
        cyc = 0;
    endtask

    typedef struct {
        int   cyc;
        logic start;
        logic rd_en, new_sum, res_valid;
        int   res_idx;
        logic done, busy;
        int   waddr, baddr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; rst2 = 1'b1; start2 = 1'b0;

        // Reset values: reset held with start requested.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
`ifdef MAC_SEQ_OVERRUN_DETECT_EN
            check("rst_overrun", overrun, 0, cyc);
`endif
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // Single frame, start at 10: checkpoint table.
        //            cyc st rd ns rv idx dn bz  w  b
        tbl[0]  = '{10, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{11, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        tbl[2]  = '{12, 0, 1, 1, 0, 0, 0, 1, 1, 1};
        tbl[3]  = '{15, 0, 1, 0, 0, 0, 0, 1, 4, 0};
        tbl[4]  = '{16, 0, 1, 1, 0, 0, 0, 1, 5, 1};
        tbl[5]  = '{18, 0, 1, 0, 1, 0, 0, 1, 7, 3};
        tbl[6]  = '{20, 0, 1, 1, 0, 0, 0, 1, 9, 1};
        tbl[7]  = '{22, 0, 1, 0, 1, 1, 0, 1, 11, 3};
        tbl[8]  = '{23, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[9]  = '{26, 0, 0, 0, 1, 2, 1, 1, 0, 0};
        tbl[10] = '{27, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{30, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        begin_scenario();
        for (int i = 0; i < 12; i++) begin
            while (cyc < tbl[i].cyc) step(1'b0, 1'b0);
            check("tbl_rd_en", rd_en, tbl[i].rd_en, cyc);
            check("tbl_new_sum", new_sum, tbl[i].new_sum, cyc);
            check("tbl_res_valid", res_valid, tbl[i].res_valid, cyc);
            check("tbl_done", done, tbl[i].done, cyc);
            check("tbl_busy", busy, tbl[i].busy, cyc);
            if (tbl[i].rd_en) begin
                check("tbl_w_rd_addr", w_rd_addr, tbl[i].waddr, cyc);
                check("tbl_buf_rd_addr", buf_rd_addr, tbl[i].baddr, cyc);
            end
            if (tbl[i].res_valid) check("tbl_res_idx", res_idx, tbl[i].res_idx, cyc);
            step(tbl[i].start, 1'b0);
        end

        // Start while busy: extra requests at 15 and 24 are ignored.
        begin_scenario();
        while (cyc < 32) begin
            if (cyc == 26) check("swb_done", done, 1, cyc);
            if (cyc == 27) check("swb_busy_low", busy, 0, cyc);
`ifdef MAC_SEQ_OVERRUN_DETECT_EN
            if (cyc == 15) check("swb_overrun_clear", overrun, 0, cyc);
            if (cyc == 16) check("swb_overrun_set", overrun, 1, cyc);
            if (cyc == 31) check("swb_overrun_sticky", overrun, 1, cyc);
`endif
            step(cyc == 10 || cyc == 15 || cyc == 24, 1'b0);
        end

        // Back-to-back frames with start held high from 10.
        begin_scenario();
        while (cyc < 45) begin
            if (cyc == 26) check("b2b_gap_rd_en", rd_en, 0, cyc);
            if (cyc == 27) begin
                check("b2b_first_issue", rd_en, 1, cyc);
                check("b2b_first_waddr", w_rd_addr, 0, cyc);
            end
            if (cyc == 34 || cyc == 38 || cyc == 42) begin
                check("b2b_res_valid", res_valid, 1, cyc);
                check("b2b_res_idx", res_idx, (cyc - 34) / 4, cyc);
            end
            if (cyc == 42) check("b2b_done", done, 1, cyc);
            step(cyc >= 10, 1'b0);
        end

        // Reset mid-frame at 15, new start at 20.
        begin_scenario();
        while (cyc < 40) begin
            if (cyc == 15) begin
                rst = 1'b1;
                #1;
                check("arst_rd_en", rd_en, 0, cyc);
                check("arst_busy", busy, 0, cyc);
                check("arst_new_sum", new_sum, 0, cyc);
                check("arst_mac_valid", mac_valid, 0, cyc);
                check("arst_res_valid", res_valid, 0, cyc);
                check("arst_done", done, 0, cyc);
                check("arst_w_rd_addr", w_rd_addr, 0, cyc);
                check("arst_buf_rd_addr", buf_rd_addr, 0, cyc);
                step(1'b0, 1'b1);
            end else begin
                if (cyc == 28) check("rmid_res0", res_valid, 1, cyc);
                if (cyc == 36) check("rmid_done", done, 1, cyc);
                step(cyc == 10 || cyc == 20, 1'b0);
            end
        end

        // Randomized traffic against the model.
        begin_scenario();
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 149) == 0);
        end
        step(1'b0, 1'b1);

        // Parameter corner: NUM_OUTS=1, RAM_LAT=2, start at 0.
        step2(1'b0, 1'b1);
        cyc2 = 0;
        step2(1'b1, 1'b0);
        while (cyc2 < 16) begin
            if (cyc2 == 3) check("corner_new_sum", new_sum2, 1, cyc2);
            if (cyc2 == 9) begin
                check("corner_res_valid", res_valid2, 1, cyc2);
                check("corner_res_idx", res_idx2, 0, cyc2);
                check("corner_done", done2, 1, cyc2);
            end
            if (cyc2 == 10) check("corner_busy_low", busy2, 0, cyc2);
            step2(1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
